// File: rtl/tt_bist_harness.sv
// On-chip BIST harness: drives LFSR stimulus into a user design, folds its
// delayed response into a 16-bit MISR and flags pass/fail against a golden value.
module tt_bist_harness #(
  parameter int          WIDTH    = 8,
  parameter int          RESP_W   = 8,
  parameter int          CYCLES   = 256,
  parameter int          LAT      = 0,
  parameter logic [15:0] SEED     = 16'h0001,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [WIDTH-1:0]  stim,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       signature
);

  localparam int CNT_W = $clog2(CYCLES + LAT + 1);
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_ABS = CNT_W'(CYCLES + LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [15:0]      r_lfsr;
  logic [15:0]      r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_stim;

  logic [15:0] w_lfsrNext;
  logic [15:0] w_misrNext;
  logic [15:0] w_respExt;
  logic        w_busy;
  logic        w_loadRun;
  logic        w_lastVec;
  logic        w_lastAbs;
  logic        w_inWindow;
  logic        w_absorb;

  // Fibonacci step for x^16+x^14+x^13+x^11+1, shared by LFSR and MISR.
  function automatic logic [15:0] polyStep(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  // The lower window bound vanishes when the DUT is combinational.
  if (LAT == 0) begin : g_noLat
    assign w_inWindow = 1'b1;
  end else begin : g_lat
    assign w_inWindow = (r_cnt >= CNT_W'(LAT));
  end

  always_comb begin
    w_busy     = (r_state == S_RUN) || (r_state == S_FLUSH);
    w_loadRun  = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    w_lastVec  = (r_cnt == LAST_VEC);
    w_lastAbs  = (r_cnt == LAST_ABS);
    w_absorb   = w_busy && w_inWindow;
    w_respExt  = 16'(resp);
    w_lfsrNext = polyStep(r_lfsr);
    w_misrNext = polyStep(r_sig) ^ w_respExt;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_nextState = S_RUN;
      end
      S_RUN: begin
        if (w_lastVec) w_nextState = (LAT == 0) ? S_DONE : S_FLUSH;
      end
      S_FLUSH: begin
        if (w_lastAbs) w_nextState = S_DONE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= '0;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_stim  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_loadRun) begin
        r_lfsr <= SEED;
        r_sig  <= '0;
        r_cnt  <= '0;
        r_stim <= SEED[WIDTH-1:0];
      end else if (w_busy) begin
        r_lfsr <= w_lfsrNext;
        r_cnt  <= r_cnt + 1'b1;
        if (w_absorb) r_sig <= w_misrNext;
        // Stimulus stops after the last vector so FLUSH and DONE present zero.
        if ((r_state == S_RUN) && !w_lastVec) r_stim <= w_lfsrNext[WIDTH-1:0];
        else r_stim <= '0;
      end
    end
  end

  assign stim      = r_stim;
  assign signature = r_sig;
  assign busy      = w_busy;
  assign done      = (r_state == S_DONE);
  assign pass      = (r_state == S_DONE) && (r_sig == EXPECTED);

endmodule
